// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - ping-pong frame sequencer for the FFT-to-BRAM capture path
module fft_frame_scheduler #(
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic                   wr_start,
    input  logic                   wr_finish,
    output logic                   wr_bank,
    output logic                   frame_valid,
    output logic                   frame_bank,
    input  logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [7:0]             overrun_count,
    output logic                   timeout,
    output logic                   busy
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_FIN,
        S_WAIT_BANK,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        full;
    logic [1:0]        full_after_done;
    logic [1:0]        full_next;
    logic              wb;
    logic              rb;
    logic [WD_W-1:0]   wd;
    logic              done_ok;
    logic              fin_ok;
    logic              start_d;
    logic              overrun_evt;
    logic              timeout_evt;

    // Consumer release is applied before the writer's bank check, so a
    // same-cycle frame_done can free the bank the writer needs next.
    always_comb begin
        done_ok         = frame_done && full[rb];
        fin_ok          = (state == S_WAIT_FIN) && wr_finish;
        full_after_done = full;
        if (done_ok) begin
            full_after_done[rb] = 1'b0;
        end
        full_next = full_after_done;
        if (fin_ok) begin
            full_next[wb] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                next_state = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                if (wr_finish) begin
                    if (!enable) begin
                        next_state = S_IDLE;
                    end else if (full_after_done[~wb]) begin
                        next_state = S_WAIT_BANK;
                    end else begin
                        next_state = S_START;
                    end
                end else if (wd == WD_LAST) begin
                    next_state = S_ERROR;
                end
            end
            S_WAIT_BANK: begin
                if (!full_after_done[wb]) begin
                    next_state = enable ? S_START : S_IDLE;
                end
            end
            S_ERROR: begin
                next_state = S_ERROR;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        start_d     = (next_state == S_START);
        overrun_evt = fin_ok && (next_state == S_WAIT_BANK);
        timeout_evt = (state == S_WAIT_FIN) && (next_state == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full          <= 2'b00;
            wb            <= 1'b0;
            rb            <= 1'b0;
            wd            <= '0;
            wr_start      <= 1'b0;
            frame_count   <= '0;
            overrun_count <= 8'd0;
            timeout       <= 1'b0;
        end else begin
            full     <= full_next;
            wr_start <= start_d;
            if (fin_ok) begin
                wb          <= ~wb;
                frame_count <= frame_count + 1'b1;
            end
            if (done_ok) begin
                rb <= ~rb;
            end
            if (state == S_START) begin
                wd <= '0;
            end else if (state == S_WAIT_FIN) begin
                wd <= wd + 1'b1;
            end
            if (overrun_evt && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end
            if (timeout_evt) begin
                timeout <= 1'b1;
            end
        end
    end

    assign wr_bank     = wb;
    assign frame_bank  = rb;
    assign frame_valid = full[rb];
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - directed self-checking bench for fft_frame_scheduler
module tb_fft_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst, enable, wr_finish, frame_done;
    logic        wr_start, wr_bank, frame_valid, frame_bank, timeout, busy;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    logic        rst2, enable2, wr_finish2, frame_done2;
    logic        wr_start2, wr_bank2, frame_valid2, frame_bank2, timeout2, busy2;
    logic [15:0] frame_count2;
    logic [7:0]  overrun_count2;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    fft_frame_scheduler #(.TIMEOUT_CYCLES(65536), .FRAME_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .wr_start(wr_start), .wr_finish(wr_finish), .wr_bank(wr_bank),
        .frame_valid(frame_valid), .frame_bank(frame_bank), .frame_done(frame_done),
        .frame_count(frame_count), .overrun_count(overrun_count),
        .timeout(timeout), .busy(busy)
    );

    fft_frame_scheduler #(.TIMEOUT_CYCLES(16), .FRAME_CNT_W(16)) dut_to (
        .clk(clk), .rst(rst2), .enable(enable2),
        .wr_start(wr_start2), .wr_finish(wr_finish2), .wr_bank(wr_bank2),
        .frame_valid(frame_valid2), .frame_bank(frame_bank2), .frame_done(frame_done2),
        .frame_count(frame_count2), .overrun_count(overrun_count2),
        .timeout(timeout2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int stuck_start;
        int lost_timeout;

        rst = 1'b1; enable = 1'b0; wr_finish = 1'b0; frame_done = 1'b0;
        rst2 = 1'b1; enable2 = 1'b0; wr_finish2 = 1'b0; frame_done2 = 1'b0;
        step();
        step();
        rst = 1'b0; rst2 = 1'b0;
        check("rst_wr_start", wr_start, 0);
        check("rst_wr_bank", wr_bank, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_busy", busy, 0);

        // Continuous capture: finish 20 cycles after start, release 5 cycles after publish
        enable = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("run_wr_start_%0d", i), wr_start, 1);
            check($sformatf("run_wr_bank_%0d", i), wr_bank, i % 2);
            for (int c = 0; c < 19; c++) begin
                frame_done = (i > 0) && (c == 4);
                step();
            end
            frame_done = 1'b0;
            wr_finish = 1'b1;
            step();
            wr_finish = 1'b0;
            check($sformatf("run_valid_%0d", i), frame_valid, 1);
            check($sformatf("run_frame_bank_%0d", i), frame_bank, i % 2);
            check($sformatf("run_count_%0d", i), frame_count, i + 1);
        end
        check("run_overrun", overrun_count, 0);

        // Consumer never releases: overrun stall after two frames
        rst = 1'b1; step(); rst = 1'b0;
        enable = 1'b1;
        step();
        repeat (3) step();
        wr_finish = 1'b1; step(); wr_finish = 1'b0;
        check("ovr_start_after_f0", wr_start, 1);
        check("ovr_bank_after_f0", wr_bank, 1);
        repeat (2) step();
        wr_finish = 1'b1; step(); wr_finish = 1'b0;
        check("ovr_no_start", wr_start, 0);
        check("ovr_count", overrun_count, 1);
        check("ovr_frame_count", frame_count, 2);
        check("ovr_busy", busy, 1);
        repeat (3) step();
        check("ovr_still_stalled", wr_start, 0);
        frame_done = 1'b1; step(); frame_done = 1'b0;
        check("rel_wr_start", wr_start, 1);
        check("rel_wr_bank", wr_bank, 0);
        check("rel_frame_bank", frame_bank, 1);
        check("rel_valid", frame_valid, 1);

        // Same-cycle finish and release with rb == new wb: no overrun
        step();
        wr_finish = 1'b1; frame_done = 1'b1;
        step();
        wr_finish = 1'b0; frame_done = 1'b0;
        check("sim_wr_start", wr_start, 1);
        check("sim_overrun", overrun_count, 1);
        check("sim_wr_bank", wr_bank, 1);
        check("sim_frame_bank", frame_bank, 0);
        check("sim_frame_count", frame_count, 3);

        // Enable drops mid-frame: frame still completes, then IDLE
        step();
        enable = 1'b0;
        repeat (2) step();
        wr_finish = 1'b1; step(); wr_finish = 1'b0;
        check("dis_busy", busy, 0);
        check("dis_valid", frame_valid, 1);
        check("dis_count", frame_count, 4);
        check("dis_wr_bank", wr_bank, 0);
        wr_finish = 1'b1; step(); wr_finish = 1'b0;
        step();
        check("stray_count", frame_count, 4);
        check("stray_wr_bank", wr_bank, 0);
        check("stray_wr_start", wr_start, 0);

        // Reset mid-frame with a published bank
        enable = 1'b1;
        repeat (2) step();
        check("mid_busy", busy, 1);
        rst = 1'b1; enable = 1'b0;
        step();
        rst = 1'b0;
        check("mr_wr_start", wr_start, 0);
        check("mr_wr_bank", wr_bank, 0);
        check("mr_valid", frame_valid, 0);
        check("mr_frame_bank", frame_bank, 0);
        check("mr_frame_count", frame_count, 0);
        check("mr_overrun", overrun_count, 0);
        check("mr_timeout", timeout, 0);
        check("mr_busy", busy, 0);

        // Watchdog with TIMEOUT_CYCLES=16 and a writer that never finishes
        enable2 = 1'b1;
        step();
        check("to_wr_start", wr_start2, 1);
        step();
        repeat (15) step();
        check("to_not_yet", timeout2, 0);
        step();
        check("to_set", timeout2, 1);
        stuck_start = 0;
        lost_timeout = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (wr_start2 !== 1'b0) stuck_start++;
            if (timeout2 !== 1'b1) lost_timeout++;
        end
        check("to_no_start", stuck_start, 0);
        check("to_sticky", lost_timeout, 0);
        check("to_busy", busy2, 1);
        rst2 = 1'b1; enable2 = 1'b0; step(); rst2 = 1'b0;
        check("to_rst_clear", timeout2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
